// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending controller: state encodings and coin values.
package vend_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_HALF = 2'd1;
    localparam logic [1:0] COIN_ONE  = 2'd2;

    // Value of the coins seen in one cycle, in 0.5-yuan units (both at once = 3).
    function automatic logic [1:0] coin_value(input logic half, input logic one);
        logic [1:0] v;
        v = (half ? COIN_HALF : 2'd0) | (one ? COIN_ONE : 2'd0);
        return v;
    endfunction

endpackage

// File: rtl/vend_ctrl_idle_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags the
// cycle in which TIMEOUT-1 idle cycles have already elapsed.
module vend_idle_timer #(
    parameter int TIMEOUT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = enable_i && (cnt_q == LAST);

    // Holds at LAST so the count can never wrap if the owner lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-coin vending controller: tracks credit and stock, runs the dispense
// req/ack handshake and pays change or refunds as one pulse per 0.5-yuan unit.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int STOCK_INIT = 8,
    parameter int TIMEOUT    = 100,
    parameter int CREDIT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pi_money_half,
    input  logic pi_money_one,
    input  logic pi_cancel,
    input  logic pi_refill,
    input  logic disp_ack,
    output logic po_cola,
    output logic po_change,
    output logic po_empty,
    output logic po_busy
);

    localparam int STOCK_W = 4;
    localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_INIT_C = STOCK_W'(STOCK_INIT);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                cola_q, change_q, empty_q, busy_q;

    logic [1:0]          coin_val;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_ext;
    logic [CREDIT_W-1:0] credit_sum;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_expire;

    assign coin_val   = coin_value(pi_money_half, pi_money_one);
    assign coin_ok    = !busy_q && (coin_val != 2'd0);
    assign coin_ext   = CREDIT_W'(coin_val);
    assign credit_sum = coin_ok ? (credit_q + coin_ext) : credit_q;

    // The timer only runs in COLLECT; any accepted coin restarts it.
    assign timer_en    = (state_q == ST_COLLECT);
    assign timer_clear = !timer_en || coin_ok;

    vend_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        case (state_q)
            ST_IDLE: begin
                if (pi_refill) begin
                    stock_d = STOCK_INIT_C;
                end
                if (coin_ok) begin
                    credit_d = coin_ext;
                    state_d  = (coin_ext >= PRICE_C) ? ST_DISPENSE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                credit_d = credit_sum;
                // A cancel wins over reaching the price: the user asked for the money back.
                if (pi_cancel) begin
                    state_d = ST_CHANGE;
                end else if (credit_sum >= PRICE_C) begin
                    state_d = ST_DISPENSE;
                end else if (!coin_ok && timer_expire) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                if (disp_ack) begin
                    stock_d  = stock_q - STOCK_W'(1);
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q != PRICE_C) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            stock_q  <= STOCK_INIT_C;
            cola_q   <= 1'b0;
            change_q <= 1'b0;
            empty_q  <= (STOCK_INIT == 0);
            busy_q   <= (STOCK_INIT == 0);
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            cola_q   <= (state_d == ST_DISPENSE);
            change_q <= (state_d == ST_CHANGE);
            empty_q  <= (stock_d == '0);
            busy_q   <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE) || (stock_d == '0);
        end
    end

    assign po_cola   = cola_q;
    assign po_change = change_q;
    assign po_empty  = empty_q;
    assign po_busy   = busy_q;

endmodule
